// File: rtl/esm_instr_buffer.sv
// Instruction buffer feeding the ESM dependency-analysis core.
// Tracks per-slot FREE/WAIT/READY/ISSUED state and issues ready entries in slot order.
module esm_instr_buffer #(
    parameter int Instr_word_size = 32,
    parameter int bs              = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [Instr_word_size-1:0] in_instr,
    input  logic                       in_alusrc,
    input  logic                       in_regwrite,
    output logic                       ida_valid,
    output logic [Instr_word_size-1:0] ida_instr,
    output logic                       ida_alusrc,
    output logic                       ida_regwrite,
    output logic [$clog2(bs)-1:0]      ida_index,
    input  logic                       rdy_valid,
    input  logic [$clog2(bs)-1:0]      rdy_index,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [Instr_word_size-1:0] issue_instr,
    output logic [$clog2(bs)-1:0]      issue_index,
    input  logic                       done_valid,
    input  logic [$clog2(bs)-1:0]      done_index,
    output logic [$clog2(bs):0]        count,
    output logic                       err
);

    localparam int bs_bits = $clog2(bs);
    localparam logic [bs_bits:0] FULL_CNT = (bs_bits+1)'(bs);

    typedef enum logic [1:0] {
        S_FREE,
        S_WAIT,
        S_READY,
        S_ISSUED
    } slot_state_t;

    slot_state_t                state_q [bs];
    logic [Instr_word_size-1:0] instr_q [bs];
    logic [bs_bits:0]           count_q;

    logic               free_hit;
    logic [bs_bits-1:0] free_idx;
    logic               rdy_hit;
    logic [bs_bits-1:0] rdy_idx;
    logic               alloc;
    logic               issue_fire;
    logic               rdy_ok;
    logic               done_ok;

    // Scan downward so the lowest-numbered match wins.
    always_comb begin
        free_hit = 1'b0;
        free_idx = '0;
        rdy_hit  = 1'b0;
        rdy_idx  = '0;
        for (int i = bs - 1; i >= 0; i--) begin
            if (state_q[i] == S_FREE) begin
                free_hit = 1'b1;
                free_idx = bs_bits'(i);
            end
            if (state_q[i] == S_READY) begin
                rdy_hit = 1'b1;
                rdy_idx = bs_bits'(i);
            end
        end
    end

    assign in_ready    = (count_q < FULL_CNT);
    assign count       = count_q;
    assign issue_valid = rdy_hit;
    assign issue_index = rdy_idx;
    assign issue_instr = instr_q[rdy_idx];

    assign alloc      = in_valid && in_ready && free_hit;
    assign issue_fire = rdy_hit && issue_ready;
    assign rdy_ok     = (state_q[rdy_index] == S_WAIT);
    assign done_ok    = done_valid && (state_q[done_index] == S_ISSUED);

    always_ff @(posedge clk) begin
        if (alloc) begin
            instr_q[free_idx] <= in_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < bs; i++) begin
                state_q[i] <= S_FREE;
            end
            count_q      <= '0;
            ida_valid    <= 1'b0;
            ida_instr    <= '0;
            ida_alusrc   <= 1'b0;
            ida_regwrite <= 1'b0;
            ida_index    <= '0;
            err          <= 1'b0;
        end else begin
            ida_valid <= alloc;
            if (alloc) begin
                state_q[free_idx] <= S_WAIT;
                ida_instr         <= in_instr;
                ida_alusrc        <= in_alusrc;
                ida_regwrite      <= in_regwrite;
                ida_index         <= free_idx;
            end
            if (rdy_valid) begin
                if (rdy_ok) begin
                    state_q[rdy_index] <= S_READY;
                end else begin
                    err <= 1'b1;
                end
            end
            if (issue_fire) begin
                state_q[rdy_idx] <= S_ISSUED;
            end
            if (done_valid) begin
                if (done_ok) begin
                    state_q[done_index] <= S_FREE;
                end else begin
                    err <= 1'b1;
                end
            end
            count_q <= count_q + (bs_bits+1)'(alloc)
                               - (bs_bits+1)'(done_ok);
        end
    end

endmodule

// File: tb/tb_esm_instr_buffer.sv
// Scoreboard bench for esm_instr_buffer: directed scenarios then randomized traffic
// against a slot-array reference model.
module tb_esm_instr_buffer;

    localparam int W  = 32;
    localparam int BS = 16;
    localparam int FREE = 0, WAIT = 1, READY = 2, ISSUED = 3;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_instr;
    logic          in_alusrc;
    logic          in_regwrite;
    logic          ida_valid;
    logic [W-1:0]  ida_instr;
    logic          ida_alusrc;
    logic          ida_regwrite;
    logic [3:0]    ida_index;
    logic          rdy_valid;
    logic [3:0]    rdy_index;
    logic          issue_valid;
    logic          issue_ready;
    logic [W-1:0]  issue_instr;
    logic [3:0]    issue_index;
    logic          done_valid;
    logic [3:0]    done_index;
    logic [4:0]    count;
    logic          err;

    esm_instr_buffer #(.Instr_word_size(W), .bs(BS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_alusrc(in_alusrc), .in_regwrite(in_regwrite),
        .ida_valid(ida_valid), .ida_instr(ida_instr), .ida_alusrc(ida_alusrc),
        .ida_regwrite(ida_regwrite), .ida_index(ida_index),
        .rdy_valid(rdy_valid), .rdy_index(rdy_index),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_instr(issue_instr), .issue_index(issue_index),
        .done_valid(done_valid), .done_index(done_index),
        .count(count), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] instr;
        logic         alusrc;
        logic         regwrite;
        logic [3:0]   idx;
    } ida_t;

    typedef struct packed {
        logic [W-1:0] instr;
        logic [3:0]   idx;
    } iss_t;

    typedef struct packed {
        logic [4:0]   count;
        logic         in_ready;
        logic         err;
        logic         iv;
        logic [3:0]   ii;
        logic [W-1:0] iinstr;
        logic         ida_v;
        ida_t         ida;
    } stat_t;

    stat_t stat_q[$];
    ida_t  ida_q[$];
    iss_t  iss_q[$];

    int checks = 0;
    int errors = 0;

    int           m_st[BS];
    logic [W-1:0] m_instr[BS];
    bit           m_err;
    bit           m_ida_pend;
    ida_t         m_ida_last;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input int st);
        for (int i = 0; i < BS; i++)
            if (m_st[i] == st) return i;
        return -1;
    endfunction

    function automatic int occupied();
        int n = 0;
        for (int i = 0; i < BS; i++)
            if (m_st[i] != FREE) n++;
        return n;
    endfunction

    function automatic int pick(input int st);
        int c[$];
        for (int i = 0; i < BS; i++)
            if (m_st[i] == st) c.push_back(i);
        if (c.size() == 0) return -1;
        return c[$urandom_range(0, c.size() - 1)];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < BS; i++) m_st[i] = FREE;
        m_err      = 1'b0;
        m_ida_pend = 1'b0;
        m_ida_last = '0;
    endtask

    task automatic step(input bit r, input bit iv, input logic [W-1:0] ins,
                        input bit as, input bit rw, input bit rv,
                        input int ri, input bit ir, input bit dv,
                        input int di);
        stat_t s;
        ida_t  e;
        iss_t  q;
        int    nst[BS];
        int    a, is_idx, n;
        @(negedge clk);
        rst         = r;
        in_valid    = iv;
        in_instr    = ins;
        in_alusrc   = as;
        in_regwrite = rw;
        rdy_valid   = rv;
        rdy_index   = 4'(ri);
        issue_ready = ir;
        done_valid  = dv;
        done_index  = 4'(di);
        n      = occupied();
        is_idx = lowest(READY);
        s.count    = 5'(n);
        s.in_ready = (n < BS);
        s.err      = m_err;
        s.iv       = (is_idx >= 0);
        s.ii       = (is_idx >= 0) ? 4'(is_idx) : 4'd0;
        s.iinstr   = (is_idx >= 0) ? m_instr[is_idx] : '0;
        s.ida_v    = m_ida_pend;
        s.ida      = m_ida_last;
        stat_q.push_back(s);
        if (r) begin
            model_reset();
            return;
        end
        nst = m_st;
        m_ida_pend = 1'b0;
        if (iv && n < BS) begin
            a = lowest(FREE);
            nst[a] = WAIT;
            m_instr[a] = ins;
            e = '{instr: ins, alusrc: as, regwrite: rw, idx: 4'(a)};
            ida_q.push_back(e);
            m_ida_pend = 1'b1;
            m_ida_last = e;
        end
        if (rv) begin
            if (m_st[ri] == WAIT) nst[ri] = READY;
            else m_err = 1'b1;
        end
        if (ir && is_idx >= 0) begin
            nst[is_idx] = ISSUED;
            q = '{instr: m_instr[is_idx], idx: 4'(is_idx)};
            iss_q.push_back(q);
        end
        if (dv) begin
            if (m_st[di] == ISSUED) nst[di] = FREE;
            else m_err = 1'b1;
        end
        m_st = nst;
    endtask

    task automatic idle(input bit ir);
        step(0, 0, '0, 0, 0, 0, 0, ir, 0, 0);
    endtask

    task automatic alloc1(input logic [W-1:0] ins);
        step(0, 1, ins, ins[0], ins[1], 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 1, 32'hdead_beef, 1, 1, 0, 0, 0, 0, 0);
    endtask

    // Monitor: samples just before each rising edge.
    initial begin : monitor
        stat_t s;
        ida_t  e;
        iss_t  q;
        forever begin
            @(negedge clk);
            #4;
            if (stat_q.size() != 0) begin
                s = stat_q.pop_front();
                chk("count", 64'(count), 64'(s.count));
                chk("in_ready", 64'(in_ready), 64'(s.in_ready));
                chk("err", 64'(err), 64'(s.err));
                chk("issue_valid", 64'(issue_valid), 64'(s.iv));
                if (s.iv) begin
                    chk("issue_index", 64'(issue_index), 64'(s.ii));
                    chk("issue_instr", 64'(issue_instr), 64'(s.iinstr));
                end
                chk("ida_valid", 64'(ida_valid), 64'(s.ida_v));
                chk("ida_hold", 64'({ida_instr, ida_alusrc, ida_regwrite,
                    ida_index}), 64'(s.ida));
                if (ida_valid) begin
                    checks++;
                    if (ida_q.size() == 0) begin
                        errors++;
                        $display("FAIL ida_unexpected index=%0d t=%0t",
                                 ida_index, $time);
                    end else begin
                        e = ida_q.pop_front();
                        chk("ida_sb_index", 64'(ida_index), 64'(e.idx));
                        chk("ida_sb_instr", 64'(ida_instr), 64'(e.instr));
                    end
                end
                if (issue_valid && issue_ready && !rst) begin
                    checks++;
                    if (iss_q.size() == 0) begin
                        errors++;
                        $display("FAIL issue_unexpected index=%0d t=%0t",
                                 issue_index, $time);
                    end else begin
                        q = iss_q.pop_front();
                        chk("iss_sb_index", 64'(issue_index), 64'(q.idx));
                        chk("iss_sb_instr", 64'(issue_instr), 64'(q.instr));
                    end
                end
            end
        end
    end

    initial begin : stim
        bit iv, rv, ir, dv, r;
        int ri, di;
        rst = 1'b1; in_valid = 0; in_instr = '0; in_alusrc = 0;
        in_regwrite = 0; rdy_valid = 0; rdy_index = '0;
        issue_ready = 0; done_valid = 0; done_index = '0;
        model_reset();
        do_reset();
        do_reset();
        idle(0);
        // back-to-back allocs 0,1,2
        alloc1(32'h1000_0001);
        alloc1(32'h1000_0002);
        alloc1(32'h1000_0003);
        idle(0);
        // fill, then a held request while full
        for (int i = 3; i < BS; i++) alloc1(32'h2000_0000 + 32'(i));
        alloc1(32'h2bad_0017);
        alloc1(32'h2bad_0018);
        step(0, 0, '0, 0, 0, 1, 5, 0, 0, 0);
        step(0, 0, '0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, '0, 0, 0, 0, 0, 0, 1, 5);
        alloc1(32'h3000_0005);
        idle(0);
        // offer switches to lower slot while stalled
        step(0, 0, '0, 0, 0, 1, 2, 0, 0, 0);
        step(0, 0, '0, 0, 0, 1, 0, 0, 0, 0);
        idle(0);
        idle(1);
        idle(0);
        // simultaneous alloc + done + issue + rdy
        do_reset();
        for (int i = 0; i < 6; i++) alloc1(32'h4000_0000 + 32'(i));
        step(0, 0, '0, 0, 0, 1, 1, 0, 0, 0);
        step(0, 0, '0, 0, 0, 1, 3, 1, 0, 0);
        step(0, 1, 32'h4444_0006, 1, 0, 1, 4, 1, 1, 1);
        idle(0);
        // rdy on a free slot sets sticky err
        do_reset();
        step(0, 0, '0, 0, 0, 1, 7, 0, 0, 0);
        idle(0);
        alloc1(32'h5000_0000);
        idle(0);
        // reset with occupancy and a strobe pending
        do_reset();
        for (int i = 0; i < 5; i++) alloc1(32'h6000_0000 + 32'(i));
        do_reset();
        idle(0);
        idle(0);
        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            r  = ($urandom_range(0, 199) == 0);
            iv = ($urandom_range(0, 2) != 0);
            ir = $urandom_range(0, 1);
            ri = pick(WAIT);
            rv = (ri >= 0) && ($urandom_range(0, 1) == 1);
            di = pick(ISSUED);
            dv = (di >= 0) && ($urandom_range(0, 2) == 0);
            if (!iv && !rv && $urandom_range(0, 99) == 0) begin
                rv = 1'b1;
                ri = $urandom_range(0, BS - 1);
            end
            if (!iv && !dv && $urandom_range(0, 99) == 0) begin
                dv = 1'b1;
                di = $urandom_range(0, BS - 1);
            end
            if (ri < 0) ri = 0;
            if (di < 0) di = 0;
            step(r, iv, $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
                 rv, ri, r ? 1'b0 : ir, dv, di);
        end
        idle(0);
        idle(0);
        @(negedge clk);
        #6;
        chk("ida_q_drained", 64'(ida_q.size()), 64'd0);
        chk("iss_q_drained", 64'(iss_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
